mmio_responder: RTL and testbench
=================================

# mmio_responder

Memory-mapped I/O responder on the Riscv151 data-side bus. It decodes CPU loads and stores in the 0x8000_0000 region, and buffers bytes between the pipeline and the UART receiver/transmitter through ready/valid handshakes. It also keeps the cycle and retired-instruction counters. Load data is registered, so the write-back stage muxes it exactly like dmem read data.

## Interface
- `ADDR_HI`, default 4'h8: value of `addr[31:28]` that selects this block.

- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `addr`  in  32  byte address from the EX stage.
- `wdata`  in  32  store data.
- `wbe`  in  4  store byte enables; any bit set means a store.
- `re`  in  1  load strobe.
- `rdata`  out  32  registered load data.
- `inst_retired`  in  1  one instruction retired this cycle.
- `rx_data`  in  8  byte from `uart_receiver`.
- `rx_valid`  in  1  receiver holds a byte.
- `rx_ready`  out  1  this block accepts the byte.
- `tx_data`  out  8  byte to `uart_transmitter`.
- `tx_valid`  out  1  byte offered to the transmitter.
- `tx_ready`  in  1  transmitter accepts the byte.

## Operation
- Hit: `addr[31:28]==ADDR_HI`. Register select: `addr[7:0]`. Misses are ignored and return 0.
- Register map:
  - 0x00 status, read-only: bit0 = tx buffer empty, bit1 = rx buffer full, other bits 0.
  - 0x04 rx data, read: returns `{24'b0, rx_buf}` and empties the rx buffer.
  - 0x08 tx data, write: requires `wbe[0]`; loads `wdata[7:0]` into the tx buffer.
  - 0x10 cycle counter, read-only.
  - 0x14 instruction counter, read-only.
  - 0x18 counter reset, write: any enabled byte clears both counters.
  - All other offsets read 0; writes to them are ignored.
- RX path:
  - 1-entry buffer `rx_buf` plus a full flag.
  - `rx_ready = !rx_full`.
  - When `rx_valid && rx_ready`, capture `rx_data` and set full.
  - A load of 0x04 while full clears full. A load of 0x04 while empty returns 0 and changes no state.
- TX path:
  - 1-entry buffer plus a full flag.
  - `tx_valid = tx_full`; `tx_data = tx_buf`.
  - When `tx_valid && tx_ready`, clear full.
  - A store to 0x08 while empty loads the buffer and sets full.
  - A store to 0x08 while full is dropped; the buffer is unchanged.
  - A store and a handshake in the same cycle: the old byte completes, the new byte is loaded, full stays 1.
- Counters:
  - 32-bit; wrap 0xFFFF_FFFF→0.
  - Cycle counter increments every cycle out of reset.
  - Instruction counter increments when `inst_retired`.
  - A reset write wins over a same-cycle increment: the value after the edge is 0.
- `re` and `wbe!=0` in the same cycle is illegal input; the store takes effect and the load returns 0.

## Timing
- Reset values:
  - `rdata`=0, `rx_ready`=1, `tx_valid`=0, `tx_data`=0.
  - Both buffers empty; both counters 0.
- Load latency is 1 cycle. `rdata` is valid the cycle after `re`.
- Loaded values are sampled before the edge:
  - Counters return their pre-increment values.
  - Status returns the flags as they were in the `re` cycle.
- RX after a read: the read-clear takes effect at the same edge as `rdata` loads. `rx_ready` rises the following cycle, so a back-to-back byte is accepted one cycle after the read.
- TX after a store: `tx_valid` rises the cycle after the store. The earliest handshake is in that cycle.
- `rdata` holds its value when `re`=0.
- Reset mid-operation (`rst` low asynchronously):
  - Any buffered rx/tx byte is discarded.
  - `tx_valid` drops immediately.
  - Pending load data is lost; `rdata`=0.

## Test plan
- Reset, then 5 cycles idle, then load 0x8000_0010 → `rdata`=5 one cycle later. Status load → 0x1.
- Hold `rx_valid` with 0xA5 → `rx_ready` drops after 1 cycle and status reads 0x3. Then load 0x04 → `rdata`=0xA5, status 0x1, and `rx_ready`=1 one cycle later.
- Store 0x8000_0008 wdata 0x41, `wbe`=4'b0001 → `tx_valid`=1 and `tx_data`=0x41 next cycle. A second store of 0x42 while `tx_ready`=0 is dropped. Raise `tx_ready` → one handshake with 0x41, then `tx_valid`=0.
- Pulse `inst_retired` 3 times, then store to 0x18 in the same cycle as a 4th pulse → instruction counter reads 0. A later read of 0x14 after 2 more pulses → 2.
- Force the cycle counter to 0xFFFF_FFFE, wait 2 cycles → read value 0 (wrap). Load 0x8000_0020 → 0. Load 0x7000_0000 → 0.
- Assert `rst` low while `tx_full` and `rx_full` are set → `tx_valid`=0, `rx_ready`=1, `rdata`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/mmio_responder_if.sv
// Data-side MMIO bus and UART byte handshakes seen by mmio_responder.
// The slave modport is the responder. The master modport is the CPU/UART side that surrounds it.
interface mmio_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        re;
  logic [31:0] rdata;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output addr, wdata, wbe, re, rx_data, rx_valid, tx_ready,
    input  rdata, rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  addr, wdata, wbe, re, rx_data, rx_valid, tx_ready,
    output rdata, rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/mmio_responder.sv
// MMIO responder: status, UART rx/tx byte buffers, and cycle/instret counters.
// Load data is registered and is valid one cycle after re.
module mmio_responder #(
  parameter logic [3:0] ADDR_HI = 4'h8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_retired,
  mmio_responder_if.slave  bus
);

  localparam logic [7:0] REG_STATUS  = 8'h00;
  localparam logic [7:0] REG_RX_DATA = 8'h04;
  localparam logic [7:0] REG_TX_DATA = 8'h08;
  localparam logic [7:0] REG_CYCLE   = 8'h10;
  localparam logic [7:0] REG_INSTRET = 8'h14;
  localparam logic [7:0] REG_CNT_RST = 8'h18;

  logic        hit;
  logic [7:0]  sel;
  logic        store;
  logic        load;

  logic [7:0]  rx_buf;
  logic        rx_full;
  logic [7:0]  tx_buf;
  logic        tx_full;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;

  logic        rx_take;
  logic        rx_rd_clear;
  logic        tx_hs;
  logic        tx_load;
  logic        cnt_clr;

  // Address bits above the register select and store-data bits above the byte lane are not decoded.
  logic        unused_bits;
  assign unused_bits = ^{bus.addr[27:8], bus.wdata[31:8]};

  assign hit   = (bus.addr[31:28] == ADDR_HI);
  assign sel   = bus.addr[7:0];
  assign store = |bus.wbe;
  // A simultaneous load and store is treated as a store only.
  assign load  = bus.re && !store;

  assign rx_take     = bus.rx_valid && !rx_full;
  assign rx_rd_clear = load && hit && (sel == REG_RX_DATA) && rx_full;

  assign tx_hs   = tx_full && bus.tx_ready;
  // A full buffer accepts a new byte only when the old byte leaves in the same cycle.
  assign tx_load = store && hit && (sel == REG_TX_DATA) && bus.wbe[0] && (!tx_full || tx_hs);

  assign cnt_clr = store && hit && (sel == REG_CNT_RST);

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    rd_mux = '0;
    if (load && hit) begin
      case (sel)
        REG_STATUS:  rd_mux = {30'b0, rx_full, !tx_full};
        REG_RX_DATA: rd_mux = rx_full ? {24'b0, rx_buf} : '0;
        REG_CYCLE:   rd_mux = cycle_cnt;
        REG_INSTRET: rd_mux = instret_cnt;
        default:     rd_mux = '0;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (bus.re) begin
      rdata_q <= rd_mux;
    end
  end

  // NOTE: the byte buffers are reset along with their flags, because tx_data is visible and must read 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_buf  <= '0;
      rx_full <= 1'b0;
    end else if (rx_take) begin
      rx_buf  <= bus.rx_data;
      rx_full <= 1'b1;
    end else if (rx_rd_clear) begin
      rx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
    end else if (tx_load) begin
      tx_buf  <= bus.wdata[7:0];
      tx_full <= 1'b1;
    end else if (tx_hs) begin
      tx_full <= 1'b0;
    end
  end

  // A counter-reset write takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt   <= cycle_cnt + 32'd1;
      instret_cnt <= instret_cnt + {31'b0, inst_retired};
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rx_ready = !rx_full;
  assign bus.tx_valid = tx_full;
  assign bus.tx_data  = tx_buf;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: a directed vector table, a counter-wrap sequence,
// randomized traffic against a queue-based reference model, and an asynchronous reset mid-operation.
module tb_mmio_responder;

  logic clk;
  logic rst;
  logic inst_retired;

  mmio_responder_if bus ();

  mmio_responder #(.ADDR_HI(4'h8)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_retired (inst_retired),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        re;
    logic        inst;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
  } op_t;

  typedef struct {
    op_t         op;
    logic [31:0] rdata;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
  } vec_t;

  int n_cmp;
  int n_bad;

  // Reference model: one-deep byte queues plus plain counters.
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  m_txd;
  logic [31:0] m_rdata;
  logic [31:0] m_cyc;
  logic [31:0] m_ins;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wbe,
                             input logic re, input logic inst, input logic rxv, input logic [7:0] rxd,
                             input logic txr);
    op_t o;
    o.addr = addr; o.wdata = wdata; o.wbe = wbe; o.re = re;
    o.inst = inst; o.rxv = rxv; o.rxd = rxd; o.txr = txr;
    return o;
  endfunction

  function automatic vec_t mv(input op_t o, input logic [31:0] rd, input logic rr, input logic tv,
                              input logic [7:0] td);
    vec_t v;
    v.op = o; v.rdata = rd; v.rx_ready = rr; v.tx_valid = tv; v.tx_data = td;
    return v;
  endfunction

  task automatic model_reset();
    rx_q.delete();
    tx_q.delete();
    m_txd   = 8'h00;
    m_rdata = 32'h0;
    m_cyc   = 32'h0;
    m_ins   = 32'h0;
  endtask

  task automatic model_step(input op_t o);
    logic       hit;
    logic [7:0] off;
    logic       st;
    logic       ld;
    logic       rxf;
    logic       txf;
    hit = (o.addr[31:28] == 4'h8);
    off = o.addr[7:0];
    st  = (o.wbe != 4'b0000);
    ld  = o.re && !st;
    rxf = (rx_q.size() != 0);
    txf = (tx_q.size() != 0);
    if (o.re) begin
      m_rdata = 32'h0;
      if (ld && hit) begin
        case (off)
          8'h00: m_rdata = {30'b0, rxf, !txf};
          8'h04: if (rxf) m_rdata = {24'b0, rx_q[0]};
          8'h10: m_rdata = m_cyc;
          8'h14: m_rdata = m_ins;
          default: m_rdata = 32'h0;
        endcase
      end
    end
    if (ld && hit && off == 8'h04 && rxf) void'(rx_q.pop_front());
    else if (!rxf && o.rxv) rx_q.push_back(o.rxd);
    if (txf && o.txr) void'(tx_q.pop_front());
    if (st && hit && off == 8'h08 && o.wbe[0] && tx_q.size() == 0) begin
      tx_q.push_back(o.wdata[7:0]);
      m_txd = o.wdata[7:0];
    end
    if (st && hit && off == 8'h18) begin
      m_cyc = 32'h0;
      m_ins = 32'h0;
    end else begin
      m_cyc = m_cyc + 32'd1;
      m_ins = m_ins + {31'b0, o.inst};
    end
  endtask

  // Drives one cycle of inputs, advances the model at the edge, then compares just after the edge.
  task automatic step(input op_t o);
    bus.addr     = o.addr;
    bus.wdata    = o.wdata;
    bus.wbe      = o.wbe;
    bus.re       = o.re;
    inst_retired = o.inst;
    bus.rx_valid = o.rxv;
    bus.rx_data  = o.rxd;
    bus.tx_ready = o.txr;
    @(posedge clk);
    model_step(o);
    #1;
    check("model_rdata",    bus.rdata,                m_rdata);
    check("model_rx_ready", {31'b0, bus.rx_ready},    {31'b0, rx_q.size() == 0});
    check("model_tx_valid", {31'b0, bus.tx_valid},    {31'b0, tx_q.size() != 0});
    check("model_tx_data",  {24'b0, bus.tx_data},     {24'b0, m_txd});
  endtask

  localparam logic [31:0] B = 32'h8000_0000;

  vec_t tbl[33];
  op_t  idle;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle  = mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    //          addr        wdata  wbe   re inst rxv rxd    txr      rdata  rr tv td
    tbl[0]  = mv(idle, 0, 1, 0, 8'h00);
    tbl[1]  = mv(idle, 0, 1, 0, 8'h00);
    tbl[2]  = mv(idle, 0, 1, 0, 8'h00);
    tbl[3]  = mv(idle, 0, 1, 0, 8'h00);
    tbl[4]  = mv(idle, 0, 1, 0, 8'h00);
    tbl[5]  = mv(mk(B+32'h10, 0, 4'h0, 1, 0, 0, 8'h00, 0), 32'd5,  1, 0, 8'h00);
    tbl[6]  = mv(mk(B+32'h00, 0, 4'h0, 1, 0, 0, 8'h00, 0), 32'h1,  1, 0, 8'h00);
    tbl[7]  = mv(mk(B,        0, 4'h0, 0, 0, 1, 8'hA5, 0), 32'h1,  0, 0, 8'h00);
    tbl[8]  = mv(mk(B+32'h00, 0, 4'h0, 1, 0, 1, 8'hA5, 0), 32'h3,  0, 0, 8'h00);
    tbl[9]  = mv(mk(B+32'h04, 0, 4'h0, 1, 0, 0, 8'h00, 0), 32'hA5, 1, 0, 8'h00);
    tbl[10] = mv(mk(B+32'h00, 0, 4'h0, 1, 0, 0, 8'h00, 0), 32'h1,  1, 0, 8'h00);
    tbl[11] = mv(mk(B+32'h08, 32'h41, 4'h1, 0, 0, 0, 8'h00, 0), 32'h1, 1, 1, 8'h41);
    tbl[12] = mv(mk(B+32'h08, 32'h42, 4'h1, 0, 0, 0, 8'h00, 0), 32'h1, 1, 1, 8'h41);
    tbl[13] = mv(mk(B,        0, 4'h0, 0, 0, 0, 8'h00, 1), 32'h1,  1, 0, 8'h41);
    tbl[14] = mv(mk(B,        0, 4'h0, 0, 0, 0, 8'h00, 1), 32'h1,  1, 0, 8'h41);
    tbl[15] = mv(mk(B,        0, 4'h0, 0, 1, 0, 8'h00, 0), 32'h1,  1, 0, 8'h41);
    tbl[16] = mv(mk(B,        0, 4'h0, 0, 1, 0, 8'h00, 0), 32'h1,  1, 0, 8'h41);
    tbl[17] = mv(mk(B,        0, 4'h0, 0, 1, 0, 8'h00, 0), 32'h1,  1, 0, 8'h41);
    tbl[18] = mv(mk(B+32'h18, 0, 4'hF, 0, 1, 0, 8'h00, 0), 32'h1,  1, 0, 8'h41);
    tbl[19] = mv(mk(B,        0, 4'h0, 0, 1, 0, 8'h00, 0), 32'h1,  1, 0, 8'h41);
    tbl[20] = mv(mk(B,        0, 4'h0, 0, 1, 0, 8'h00, 0), 32'h1,  1, 0, 8'h41);
    tbl[21] = mv(mk(B+32'h14, 0, 4'h0, 1, 0, 0, 8'h00, 0), 32'd2,  1, 0, 8'h41);
    tbl[22] = mv(mk(B+32'h10, 0, 4'h0, 1, 0, 0, 8'h00, 0), 32'd3,  1, 0, 8'h41);
    tbl[23] = mv(mk(B+32'h20, 0, 4'h0, 1, 0, 0, 8'h00, 0), 32'h0,  1, 0, 8'h41);
    tbl[24] = mv(mk(32'h7000_0010, 0, 4'h0, 1, 0, 0, 8'h00, 0), 32'h0, 1, 0, 8'h41);
    tbl[25] = mv(mk(B+32'h10, 32'h9, 4'h3, 1, 0, 0, 8'h00, 0), 32'h0, 1, 0, 8'h41);
    tbl[26] = mv(mk(B+32'h08, 32'h77, 4'h2, 0, 0, 0, 8'h00, 0), 32'h0, 1, 0, 8'h41);
    tbl[27] = mv(mk(B+32'h00, 0, 4'h0, 1, 0, 0, 8'h00, 0), 32'h1,  1, 0, 8'h41);
    tbl[28] = mv(mk(B+32'h04, 0, 4'h0, 1, 0, 0, 8'h00, 0), 32'h0,  1, 0, 8'h41);
    tbl[29] = mv(mk(B+32'h08, 32'h55, 4'h1, 0, 0, 0, 8'h00, 0), 32'h0, 1, 1, 8'h55);
    tbl[30] = mv(mk(B+32'h08, 32'h66, 4'h1, 0, 0, 0, 8'h00, 1), 32'h0, 1, 1, 8'h66);
    tbl[31] = mv(mk(B,        0, 4'h0, 0, 0, 0, 8'h00, 1), 32'h0,  1, 0, 8'h66);
    tbl[32] = mv(mk(B+32'h00, 0, 4'h0, 1, 0, 0, 8'h00, 0), 32'h1,  1, 0, 8'h66);

    // Reset state.
    rst = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.wbe = '0; bus.re = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_ready = 1'b0;
    inst_retired = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata",    bus.rdata,             32'h0);
    check("reset_rx_ready", {31'b0, bus.rx_ready}, 32'h1);
    check("reset_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    check("reset_tx_data",  {24'b0, bus.tx_data},  32'h0);
    #4 rst = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 33; i++) begin
      step(tbl[i].op);
      check($sformatf("vec%0d_rdata", i),    bus.rdata,             tbl[i].rdata);
      check($sformatf("vec%0d_rx_ready", i), {31'b0, bus.rx_ready}, {31'b0, tbl[i].rx_ready});
      check($sformatf("vec%0d_tx_valid", i), {31'b0, bus.tx_valid}, {31'b0, tbl[i].tx_valid});
      check($sformatf("vec%0d_tx_data", i),  {24'b0, bus.tx_data},  {24'b0, tbl[i].tx_data});
    end

    // Cycle counter wrap: preload just below the top and read after two more edges.
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    step(idle);
    release dut.cycle_cnt;
    m_cyc = 32'hFFFF_FFFE;
    step(idle);
    step(idle);
    step(mk(B+32'h10, 0, 4'h0, 1, 0, 0, 8'h00, 0));
    check("cycle_wrap", bus.rdata, 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      op_t o;
      logic [7:0] off;
      case ($urandom_range(0, 6))
        0: off = 8'h00;
        1: off = 8'h04;
        2: off = 8'h08;
        3: off = 8'h10;
        4: off = 8'h14;
        5: off = ($urandom_range(0, 9) == 0) ? 8'h18 : 8'h08;
        default: off = 8'($urandom);
      endcase
      o.addr  = {($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h8, 20'($urandom), off};
      o.wdata = $urandom;
      o.wbe   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      o.re    = ($urandom_range(0, 9) < 4);
      o.inst  = 1'($urandom);
      o.rxv   = 1'($urandom);
      o.rxd   = 8'($urandom);
      o.txr   = 1'($urandom);
      step(o);
    end

    // Asynchronous reset with both buffers full and nonzero load data pending.
    step(mk(B+32'h08, 32'h5A, 4'h1, 0, 0, 1, 8'hC3, 0));
    step(mk(B+32'h10, 0, 4'h0, 1, 0, 0, 8'h00, 0));
    check("pre_rst_tx_valid", {31'b0, bus.tx_valid}, 32'h1);
    check("pre_rst_rx_ready", {31'b0, bus.rx_ready}, 32'h0);
    #3 rst = 1'b0;
    #1;
    check("async_rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    check("async_rst_rx_ready", {31'b0, bus.rx_ready}, 32'h1);
    check("async_rst_rdata",    bus.rdata,             32'h0);
    check("async_rst_tx_data",  {24'b0, bus.tx_data},  32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(mk(B+32'h00, 0, 4'h0, 1, 0, 0, 8'h00, 0));
    check("post_rst_status", bus.rdata, 32'h1);
    step(mk(B+32'h10, 0, 4'h0, 1, 0, 0, 8'h00, 0));
    check("post_rst_cycle", bus.rdata, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
